// File: rtl/be_word_assembler.sv
// be_word_assembler
//
// Packs a byte-serial stream into full-width big-endian words: the first byte
// of a word lands in the most-significant lane. A word completes when its last
// lane is filled or when the byte carries in_last (short word); unfilled lanes
// read as zero and out_count reports how many lanes are valid.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. A producer must hold data stable while valid && !ready; this
// block holds out_data/out_count stable while out_valid && !out_ready.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   in_data/in_last valid
//   in_ready   block can accept a byte (registered state only)
//   in_data    byte, first byte of a word is most significant
//   in_last    byte terminates the current word early
//   out_valid  out_data/out_count hold a completed word
//   out_ready  consumer takes the word
//   out_data   assembled word, unfilled lanes zero
//   out_count  number of valid bytes, 1..WORD

`ifndef WIDTH
`define WIDTH 8
`endif
`ifndef WORD
`define WORD 4
`endif

module be_word_assembler #(
  parameter int WIDTH = `WIDTH,
  parameter int WORD  = `WORD,
  parameter int CW    = $clog2(WORD) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH*WORD-1:0] out_data,
  output logic [CW-1:0]         out_count
);

  localparam int FULLW = WIDTH * WORD;

  logic [FULLW-1:0] r_acc;
  logic [CW-1:0]    r_idx;
  logic             r_acc_full;
  // Byte count of the word parked in r_acc while r_acc_full is set.
  logic [CW-1:0]    r_held_cnt;
  logic [FULLW-1:0] r_out_data;
  logic [CW-1:0]    r_out_count;
  logic             r_out_valid;

  logic             w_in_hs;
  logic             w_out_free;
  logic             w_complete;
  logic [FULLW-1:0] w_merged;
  logic [CW-1:0]    w_count;

  assign in_ready  = ~r_acc_full;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;

  assign w_in_hs    = in_valid & ~r_acc_full;
  // Output register can take a word this edge: empty, or emptying now.
  assign w_out_free = ~r_out_valid | out_ready;
  assign w_complete = w_in_hs & (in_last | (r_idx == CW'(WORD - 1)));
  assign w_count    = r_idx + CW'(1);

  // Accumulator with the incoming byte dropped into lane (WORD-1-idx).
  always_comb begin
    w_merged = r_acc;
    for (int k = 0; k < WORD; k++) begin
      if (r_idx == CW'(k)) begin
        w_merged[(WORD-1-k)*WIDTH +: WIDTH] = in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_idx       <= '0;
      r_acc_full  <= 1'b0;
      r_held_cnt  <= '0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (r_acc_full) begin
        // No bytes are accepted while a word is parked; drain it first.
        if (w_out_free) begin
          r_out_data  <= r_acc;
          r_out_count <= r_held_cnt;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_idx       <= '0;
          r_acc_full  <= 1'b0;
        end
      end else if (w_in_hs) begin
        if (w_complete) begin
          if (w_out_free) begin
            r_out_data  <= w_merged;
            r_out_count <= w_count;
            r_out_valid <= 1'b1;
            r_acc       <= '0;
            r_idx       <= '0;
          end else begin
            r_acc      <= w_merged;
            r_held_cnt <= w_count;
            r_acc_full <= 1'b1;
            r_idx      <= '0;
          end
        end else begin
          r_acc <= w_merged;
          r_idx <= w_count;
        end
      end
    end
  end

endmodule

// File: tb/tb_be_word_assembler.sv
module tb_be_word_assembler;

  localparam int W     = 8;
  localparam int WD    = 4;
  localparam int FULLW = W * WD;
  localparam int CW    = $clog2(WD) + 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  wire              out_ready;
  logic [FULLW-1:0] out_data;
  logic [CW-1:0]    out_count;

  // out_ready is either a directed level or a per-cycle coin flip.
  logic rdy_cmd;
  logic rand_rdy;
  logic rand_bit;
  assign out_ready = rand_rdy ? rand_bit : rdy_cmd;

  be_word_assembler #(.WIDTH(W), .WORD(WD)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rand_bit = 1'($urandom_range(0, 1));
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [CW+FULLW-1:0] exp_q[$];
  logic [FULLW-1:0]    m_word;
  int                  m_idx;
  logic                hold_prev;
  logic [CW+FULLW-1:0] prev_out;

  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && out_valid)
        check("out_stable", {out_count, out_data}, prev_out);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_word", {out_count, out_data}, '0);
        else check("word", {out_count, out_data}, exp_q.pop_front());
      end
      hold_prev = out_valid && !out_ready;
      prev_out  = {out_count, out_data};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [W-1:0] d, input logic last);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("in_ready_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    m_word[(WD-1-m_idx)*W +: W] = d;
    if (last || m_idx == WD - 1) begin
      exp_q.push_back({CW'(m_idx + 1), m_word});
      m_word = '0;
      m_idx  = 0;
    end else begin
      m_idx++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = W'($urandom);
  endtask

  task automatic wait_out(input string tag, input logic [FULLW-1:0] d, input logic [CW-1:0] c);
    int n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"}, out_data, d);
    check({tag, "_count"}, out_count, c);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] b;
    int start;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    rdy_cmd = 1'b1; rand_rdy = 1'b0;
    m_word = '0; m_idx = 0; hold_prev = 1'b0;
    #1 rst = 1'b1;
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_count", out_count, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    step();

    // Full word, exactly one valid cycle
    send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'hBE, 0); send_byte(8'hEF, 0);
    check("full_valid", out_valid, 1);
    check("full_data", out_data, 32'hDEADBEEF);
    check("full_count", out_count, 4);
    step();
    check("full_one_cycle", out_valid, 0);

    // Short words, then a full word proving acc was cleared
    send_byte(8'h12, 0); send_byte(8'h34, 1);
    wait_out("short2", 32'h12340000, 2);
    send_byte(8'hAB, 1);
    wait_out("short1", 32'hAB000000, 1);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
    wait_out("after_short", 32'h01020304, 4);
    step();

    // Backpressure
    rdy_cmd = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_byte(W'(i), 0);
      if (i == 6) check("bp_ready_before_last", in_ready, 1);
    end
    check("bp_ready_low", in_ready, 0);
    check("bp_hold_data", out_data, 32'h00010203);
    step(); step();
    check("bp_hold_data2", out_data, 32'h00010203);
    check("bp_ready_low2", in_ready, 0);
    rdy_cmd = 1'b1;
    step();
    check("bp_second_valid", out_valid, 1);
    check("bp_second_data", out_data, 32'h04050607);
    check("bp_ready_back", in_ready, 1);
    step();
    check("bp_drained", out_valid, 0);

    // Streaming at one byte per cycle
    start = cyc;
    for (int i = 0; i < 16; i++) begin
      send_byte(W'($urandom), 0);
      if (i % 4 == 3) check("stream_word_valid", out_valid, 1);
    end
    check("stream_cycles", 64'(cyc - start), 16);
    step();

    // Reset mid-word with a word waiting in the output register
    rdy_cmd = 1'b0;
    send_byte(8'h55, 0); send_byte(8'h66, 0); send_byte(8'h77, 0); send_byte(8'h88, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    check("pre_reset_valid", out_valid, 1);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_count", out_count, 0);
    check("mid_rst_in_ready", in_ready, 1);
    exp_q.delete();
    m_word = '0;
    m_idx  = 0;
    step();
    rst = 1'b0;
    rdy_cmd = 1'b1;
    step();
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    wait_out("post_rst", 32'h11223344, 4);
    step();

    // Random handshakes on both sides
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_last  = 1'($urandom_range(0, 1));
        step();
      end
      b = W'($urandom);
      send_byte(b, (i == 999) ? 1'b1 : ($urandom_range(0, 3) == 0));
    end
    rand_rdy = 1'b0;
    rdy_cmd  = 1'b1;
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) step();
    check("drain_empty", 64'(exp_q.size()), 0);
    check("final_in_ready", in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/be_word_assembler.md
# be_word_assembler

Assembles a big-endian byte stream into full-width words. Byte 0 of each word lands in the most-significant byte lane, matching the byte ordering used by the CPU's big-endian register storage. Sits between byte-serial sources (test loaders, a UART/debug byte path) and word-wide consumers such as register or memory write ports. Uses valid/ready handshakes on both sides, supports early termination of short words, and sustains one byte per cycle.

## Interface
- `WIDTH`, default `` `WIDTH `` (8): bits per byte lane.
- `WORD`, default `` `WORD `` (4): byte lanes per word. FULLW = WIDTH*WORD.
- `CW`, default $clog2(WORD)+1: width of the byte count.

Ports:
- `clk`  in  1  : the single clock; all state changes on its rising edge.
- `rst`  in  1  : reset, asynchronous and active-high.
- `in_valid`  in  1  : `in_data`/`in_last` are valid.
- `in_ready`  out  1  : the block can accept a byte.
- `in_data`  in  WIDTH  : byte; first byte of a word is most significant.
- `in_last`  in  1  : this byte terminates the current word early.
- `out_valid`  out  1  : `out_data`/`out_count` hold a completed word.
- `out_ready`  in  1  : the consumer takes the word.
- `out_data`  out  FULLW  : assembled word; lanes not filled are zero.
- `out_count`  out  CW  : number of valid bytes, 1..WORD.

## Operation
- Input handshake: in_valid && in_ready at a rising edge. Output handshake: out_valid && out_ready at a rising edge.
- State:
  - Accumulator `acc[FULLW-1:0]`.
  - Byte index `idx` in 0..WORD-1.
  - Flag `acc_full`.
  - Output register holding out_data/out_count/out_valid.
- Byte placement: the accepted byte at index k is written to `acc[(WORD-1-k)*WIDTH +: WIDTH]`.
- Word completion: an accepted byte with idx == WORD-1, or with in_last == 1, completes the word.
  - Count = idx+1.
  - Completion clears acc to 0 and idx to 0.
- Transfer on completion:
  - If the output register is empty, or is handshaking in the same cycle, the word (with this byte merged) loads into the output register at that edge.
  - Otherwise the completed word stays in acc and `acc_full` is set.
- `acc_full` drains:
  - The held word moves into the output register at the edge where the output register is empty or handshaking.
  - At that edge `acc_full` clears and acc/idx are reset.
- `in_ready` = !acc_full. It comes from registered state only, never combinationally from out_ready or in_valid.
- Data-path rules:
  - Non-completing accepted bytes only increment idx.
  - in_last with idx == WORD-1 is a normal full word, count WORD.
  - in_data is ignored when the input handshake does not occur.
- Output stability: out_data and out_count are held constant while out_valid && !out_ready.
- Words are delivered strictly in arrival order. No word is dropped or duplicated.

## Timing
- Reset values (asynchronous, apply immediately):
  - out_valid = 0, out_data = 0, out_count = 0.
  - acc = 0, idx = 0, acc_full = 0.
  - in_ready = 1.
- Reset mid-word discards partial bytes and any held or output word.
- Latency: the completing byte accepted at edge N gives out_valid = 1 starting in the cycle after edge N, provided the output register was free.
- Throughput: one byte per cycle, with no bubbles between words, while out_ready is held high.
- Backpressure: with out_ready low, one word sits in the output register and a second completes into acc. in_ready goes low the cycle after the second word completes.
- Simultaneous output handshake and acc_full drain: the held word loads into the output register at the same edge, and in_ready returns high the following cycle.
- Simultaneous output handshake and completing byte: the new word replaces the outgoing one at that edge, and out_valid stays high.

## Test plan
- Full word:
  - Stimulus: out_ready = 1; send DE, AD, BE, EF on consecutive cycles.
  - Required: out_data = 0xDEADBEEF and out_count = 4, valid for exactly one cycle, starting the cycle after EF is accepted.
- Short word:
  - Stimulus: send 12, then 34 with in_last.
  - Required: 0x12340000, count 2.
  - Then a lone AB with in_last gives 0xAB000000, count 1.
  - Then a 4-byte word 01 02 03 04 gives 0x01020304, count 4, confirming acc was cleared.
- Backpressure:
  - Stimulus: out_ready = 0; stream 00..07 with in_valid held.
  - Required: in_ready drops after 07 is accepted, and out_data holds 0x00010203 stable.
  - Then raise out_ready: 0x00010203 followed by 0x04050607 in consecutive cycles, and in_ready returns to 1.
- Streaming: 16 random bytes back-to-back with out_ready = 1 produce 4 words, each in consecutive output cycles with correct big-endian packing. Check against a scoreboard.
- Reset mid-word:
  - Stimulus: send AA, BB; assert rst asynchronously between edges.
  - Required: out_valid, out_data and out_count go to 0 immediately, and in_ready = 1.
  - Afterwards 11 22 33 44 gives 0x11223344, not contaminated by AA/BB.
- Random handshake: in_valid and out_ready each toggled randomly (50%) over 1000 bytes with random in_last.
  - Required: no byte loss, in-order words, correct counts.
  - out_data stable whenever out_valid && !out_ready.
